gauss_blur_3x3: RTL and testbench

Streaming 3x3 Gaussian blur on the 640x480 RGB pixel stream, using kernel [1 2 1; 2 4 2; 1 2 1]/16 per channel. Sits directly upstream of the per-pixel RGB output stage. It consumes raster-ordered RGB pixels with row/col coordinates and emits blurred RGB with the row/col of the filtered (centre) pixel. The downstream stage blanks any coordinate this block does not emit.

---
 rtl/blur_pkg.sv | 42 ++++
 rtl/gauss_blur_3x3_if.sv | 30 +++
 rtl/blur_line_buffer.sv | 29 ++
 rtl/gauss_blur_3x3.sv | 203 ++++++++++++++++++++
 tb/tb_gauss_blur_3x3.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/blur_pkg.sv
// Shared constants, pixel type and kernel helpers for the 3x3 Gaussian blur.
package blur_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int COORD_W   = 13;

  localparam int W_CORNER  = 1;
  localparam int W_EDGE    = 2;
  localparam int W_CENTRE  = 4;

  localparam int RND_ADD   = 8;
  localparam int RND_SHIFT = 4;
  localparam int SUM_W     = 12;

  typedef logic [7:0] chan_t;

  typedef struct packed {
    chan_t r;
    chan_t g;
    chan_t b;
  } rgb_t;

  // Weight of window tap (row, col), both indexed 0..2 with the centre at (1,1).
  function automatic logic [2:0] kernel_weight(input int row, input int col);
    if (row == 1 && col == 1) begin
      return 3'(W_CENTRE);
    end else if (row == 1 || col == 1) begin
      return 3'(W_EDGE);
    end else begin
      return 3'(W_CORNER);
    end
  endfunction

  // Channel 2 is red, 1 is green, 0 is blue.
  function automatic chan_t rgb_chan(input rgb_t p, input int ch);
    logic [23:0] flat;
    flat = p;
    return flat[8*ch +: 8];
  endfunction

endpackage

// File: rtl/gauss_blur_3x3_if.sv
// Pixel-stream bundle for the blur: raster input with coordinates and bypass,
// filtered output tagged with the centre coordinates.
interface gauss_blur_3x3_if #(
  parameter int COORD_W = blur_pkg::COORD_W
);
  logic                 iDVAL;
  blur_pkg::chan_t      iR;
  blur_pkg::chan_t      iG;
  blur_pkg::chan_t      iB;
  logic [COORD_W-1:0]   iROW;
  logic [COORD_W-1:0]   iCOL;
  logic                 iBYPASS;

  logic                 oDVAL;
  blur_pkg::chan_t      oR;
  blur_pkg::chan_t      oG;
  blur_pkg::chan_t      oB;
  logic [COORD_W-1:0]   oROW;
  logic [COORD_W-1:0]   oCOL;

  modport master (
    output iDVAL, iR, iG, iB, iROW, iCOL, iBYPASS,
    input  oDVAL, oR, oG, oB, oROW, oCOL
  );

  modport slave (
    input  iDVAL, iR, iG, iB, iROW, iCOL, iBYPASS,
    output oDVAL, oR, oG, oB, oROW, oCOL
  );
endinterface

// File: rtl/blur_line_buffer.sv
// One-line pixel store: a write port and a registered read port; a read of the
// address being written in the same cycle returns the previous contents.
module blur_line_buffer
  import blur_pkg::*;
#(
  parameter int DEPTH = H_ACTIVE,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  rgb_t          wdata_i,
  input  logic [AW-1:0] raddr_i,
  output rgb_t          rdata_o
);

  rgb_t mem_q [0:DEPTH-1];
  rgb_t rdata_q;

  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gauss_blur_3x3.sv
// Streaming 3x3 Gaussian blur ([1 2 1; 2 4 2; 1 2 1]/16 per channel) with two
// line buffers, a 3x3 window and a fixed three-cycle input-to-output latency.
module gauss_blur_3x3 #(
  parameter int H_ACTIVE = blur_pkg::H_ACTIVE,
  parameter int V_ACTIVE = blur_pkg::V_ACTIVE,
  parameter int COORD_W  = blur_pkg::COORD_W
) (
  input  logic           iCLK,
  input  logic           iRST,
  gauss_blur_3x3_if.slave bus
);
  import blur_pkg::*;

  localparam int AW = $clog2(H_ACTIVE);

  typedef logic [COORD_W-1:0] coord_t;

  // Stage 0: input register; out-of-range pixels never enter the pipeline.
  logic   in_ok;
  logic   v0_q;
  logic   byp0_q;
  rgb_t   pix0_q;
  coord_t row0_q;
  coord_t col0_q;

  assign in_ok = bus.iDVAL
              && (bus.iROW < coord_t'(V_ACTIVE))
              && (bus.iCOL < coord_t'(H_ACTIVE));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      v0_q   <= 1'b0;
      byp0_q <= 1'b0;
      pix0_q <= '0;
      row0_q <= '0;
      col0_q <= '0;
    end else begin
      v0_q <= in_ok;
      if (in_ok) begin
        byp0_q <= bus.iBYPASS;
        pix0_q <= {bus.iR, bus.iG, bus.iB};
        row0_q <= bus.iROW;
        col0_q <= bus.iCOL;
      end
    end
  end

  // Stage 1: line-buffer read of the two rows above.
  rgb_t   lb1_rd;
  rgb_t   lb2_rd;
  logic   v1_q;
  logic   byp1_q;
  rgb_t   pix1_q;
  coord_t row1_q;
  coord_t col1_q;

  blur_line_buffer #(.DEPTH(H_ACTIVE), .AW(AW)) u_lb1 (
    .clk_i   (iCLK),
    .we_i    (v0_q),
    .waddr_i (col0_q[AW-1:0]),
    .wdata_i (pix0_q),
    .raddr_i (col0_q[AW-1:0]),
    .rdata_o (lb1_rd)
  );

  // LB2 inherits LB1's old word one cycle later, once that word has been read out.
  blur_line_buffer #(.DEPTH(H_ACTIVE), .AW(AW)) u_lb2 (
    .clk_i   (iCLK),
    .we_i    (v1_q),
    .waddr_i (col1_q[AW-1:0]),
    .wdata_i (lb1_rd),
    .raddr_i (col0_q[AW-1:0]),
    .rdata_o (lb2_rd)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      v1_q   <= 1'b0;
      byp1_q <= 1'b0;
      pix1_q <= '0;
      row1_q <= '0;
      col1_q <= '0;
    end else begin
      v1_q <= v0_q;
      if (v0_q) begin
        byp1_q <= byp0_q;
        pix1_q <= pix0_q;
        row1_q <= row0_q;
        col1_q <= col0_q;
      end
    end
  end

  // Stage 2: window shift (row 0 = two lines up, column 2 = newest) and centre capture.
  rgb_t   win_q [3][3];
  rgb_t   win_d [3][3];
  logic   trig_d;
  logic   pass_d;
  logic   trig2_q;
  logic   pass2_q;
  coord_t crow2_q;
  coord_t ccol2_q;

  always_comb begin
    win_d = win_q;
    if (v1_q) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = lb2_rd;
      win_d[1][2] = lb1_rd;
      win_d[2][2] = pix1_q;
    end
  end

  // A centre on row 0 or col 0 sees stale buffer/window data, so it passes through.
  assign trig_d = v1_q && (row1_q != '0) && (col1_q != '0);
  assign pass_d = byp1_q || (row1_q == coord_t'(1)) || (col1_q == coord_t'(1));

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_win_row
      always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
          for (int j = 0; j < 3; j++) begin
            win_q[gi][j] <= '0;
          end
        end else begin
          win_q[gi] <= win_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      trig2_q <= 1'b0;
      pass2_q <= 1'b0;
      crow2_q <= '0;
      ccol2_q <= '0;
    end else begin
      trig2_q <= trig_d;
      if (v1_q) begin
        pass2_q <= pass_d;
        crow2_q <= row1_q - coord_t'(1);
        ccol2_q <= col1_q - coord_t'(1);
      end
    end
  end

  // Stage 3: per-channel weighted sum, rounding and output register.
  chan_t  filt_d [3];
  rgb_t   opix_d;
  logic   odval_q;
  rgb_t   opix_q;
  coord_t orow_q;
  coord_t ocol_q;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [SUM_W-1:0] sum_d;

      always_comb begin
        sum_d = '0;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            sum_d = sum_d + SUM_W'(kernel_weight(i, j)) * SUM_W'(rgb_chan(win_q[i][j], gi));
          end
        end
      end

      assign filt_d[gi] = pass2_q ? rgb_chan(win_q[1][1], gi)
                                  : chan_t'((sum_d + SUM_W'(RND_ADD)) >> RND_SHIFT);
    end
  endgenerate

  assign opix_d = {filt_d[2], filt_d[1], filt_d[0]};

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      odval_q <= 1'b0;
      opix_q  <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
    end else begin
      odval_q <= trig2_q;
      if (trig2_q) begin
        opix_q <= opix_d;
        orow_q <= crow2_q;
        ocol_q <= ccol2_q;
      end
    end
  end

  assign bus.oDVAL = odval_q;
  assign bus.oR    = opix_q.r;
  assign bus.oG    = opix_q.g;
  assign bus.oB    = opix_q.b;
  assign bus.oROW  = orow_q;
  assign bus.oCOL  = ocol_q;

endmodule

// File: tb/tb_gauss_blur_3x3.sv
// Directed bench for gauss_blur_3x3 on a reduced 16x12 frame: table vectors for
// the single-white-pixel response plus frame-level and multi-cycle corner checks.
module tb_gauss_blur_3x3;

  localparam int TH = 16;
  localparam int TV = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  gauss_blur_3x3_if bus ();

  gauss_blur_3x3 #(.H_ACTIVE(TH), .V_ACTIVE(TV)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          row;
    int          col;
    logic [23:0] exp;
  } vec_t;

  vec_t        white_tbl [12];
  logic [23:0] img      [TV][TH];
  bit          byp_img  [TV][TH];
  logic [23:0] cont_got [TV][TH];
  int          acc_edge [TV][TH];

  // Capture side, owned by the monitor.
  logic [23:0] got      [TV][TH];
  int          seen     [TV][TH];
  int          out_edge [TV][TH];
  bit          dval_log [8192];
  int          n_emit = 0;
  int          out_of_area = 0;
  bit          clr_cap = 1'b0;
  int          last_acc = 0;

  always @(negedge clk) begin
    if (clr_cap) begin
      for (int r = 0; r < TV; r++) begin
        for (int c = 0; c < TH; c++) begin
          got[r][c]      = '0;
          seen[r][c]     = 0;
          out_edge[r][c] = -1;
        end
      end
      n_emit      = 0;
      out_of_area = 0;
    end
    if (cyc < 8192) dval_log[cyc] = bus.oDVAL;
    if (bus.oDVAL === 1'b1) begin
      n_emit++;
      if (int'(bus.oROW) < TV && int'(bus.oCOL) < TH) begin
        got[bus.oROW][bus.oCOL]      = {bus.oR, bus.oG, bus.oB};
        seen[bus.oROW][bus.oCOL]     = seen[bus.oROW][bus.oCOL] + 1;
        out_edge[bus.oROW][bus.oCOL] = cyc;
      end else begin
        out_of_area++;
      end
    end
  end

  task automatic check(input string name, input int r, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (r=%0d c=%0d): got %0h, expected %0h", name, r, c, act, exp);
    end
  endtask

  function automatic logic [23:0] hash_pix(input int r, input int c);
    return {8'(r * 37 + c * 11 + 5), 8'((r * 13) ^ (c * 29)), 8'(r * c + 71)};
  endfunction

  // Reference blur of centre (cr,cc) straight from the frame image.
  function automatic logic [23:0] model(input int cr, input int cc, input bit byp);
    logic [23:0] res;
    logic [23:0] p;
    int s;
    if (byp || cr == 0 || cc == 0) return img[cr][cc];
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      s = 0;
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          p = img[cr + dr][cc + dc];
          s += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * int'(p[8*ch +: 8]);
        end
      end
      res[8*ch +: 8] = 8'((s + 8) / 16);
    end
    return res;
  endfunction

  task automatic drive_pix(input int r, input int c, input logic [23:0] p, input bit byp);
    @(negedge clk);
    bus.iDVAL   = 1'b1;
    bus.iROW    = 13'(r);
    bus.iCOL    = 13'(c);
    bus.iR      = p[23:16];
    bus.iG      = p[15:8];
    bus.iB      = p[7:0];
    bus.iBYPASS = byp;
    last_acc    = cyc + 1;
    if (r < TV && c < TH) acc_edge[r][c] = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.iDVAL   = 1'b0;
      bus.iBYPASS = 1'b0;
    end
  endtask

  task automatic clear_capture();
    clr_cap = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr_cap = 1'b0;
  endtask

  task automatic send_frame(input int gap, input bit use_byp, input bit inject);
    for (int r = 0; r < TV; r++) begin
      for (int c = 0; c < TH; c++) begin
        drive_pix(r, c, img[r][c], use_byp ? byp_img[r][c] : 1'b0);
        if (gap > 0) idle(gap);
        if (inject && r == 4 && c == 3) begin
          drive_pix(4, 700, 24'hFF0000, 1'b0);
          drive_pix(TV, 3, 24'h00FF00, 1'b0);
        end
      end
    end
    idle(6);
  endtask

  task automatic check_frame(input string tag, input bit use_byp);
    int border_hits;
    border_hits = 0;
    for (int r = 0; r < TV - 1; r++) begin
      for (int c = 0; c < TH - 1; c++) begin
        check({tag, "_seen"}, r, c, 32'(seen[r][c]), 32'd1);
        check({tag, "_pix"}, r, c, {8'h0, got[r][c]},
              {8'h0, model(r, c, use_byp && byp_img[r + 1][c + 1])});
      end
    end
    for (int r = 0; r < TV; r++) border_hits += seen[r][TH - 1];
    for (int c = 0; c < TH - 1; c++) border_hits += seen[TV - 1][c];
    check({tag, "_last_row_col_emitted"}, TV - 1, TH - 1, 32'(border_hits), 32'd0);
    check({tag, "_out_of_area"}, -1, -1, 32'(out_of_area), 32'd0);
    check({tag, "_emit_count"}, -1, -1, 32'(n_emit), 32'((TV - 1) * (TH - 1)));
  endtask

  initial begin
    int a;
    int nz;
    int emit_before;

    white_tbl[0]  = '{5, 7, 24'h404040};
    white_tbl[1]  = '{4, 7, 24'h202020};
    white_tbl[2]  = '{6, 7, 24'h202020};
    white_tbl[3]  = '{5, 6, 24'h202020};
    white_tbl[4]  = '{5, 8, 24'h202020};
    white_tbl[5]  = '{4, 6, 24'h101010};
    white_tbl[6]  = '{4, 8, 24'h101010};
    white_tbl[7]  = '{6, 6, 24'h101010};
    white_tbl[8]  = '{6, 8, 24'h101010};
    white_tbl[9]  = '{3, 7, 24'h000000};
    white_tbl[10] = '{5, 9, 24'h000000};
    white_tbl[11] = '{7, 5, 24'h000000};

    bus.iDVAL = 1'b0; bus.iR = '0; bus.iG = '0; bus.iB = '0;
    bus.iROW = '0; bus.iCOL = '0; bus.iBYPASS = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dval", -1, -1, {31'h0, bus.oDVAL}, 32'h0);
    check("rst_rgb", -1, -1, {8'h0, bus.oR, bus.oG, bus.oB}, 32'h0);
    check("rst_coord", -1, -1, {6'h0, bus.oROW, bus.oCOL}, 32'h0);
    rst = 1'b0;
    idle(2);

    // Uniform frame, continuous input; also timing of (5,7) and silence after (5,0).
    for (int r = 0; r < TV; r++) for (int c = 0; c < TH; c++) img[r][c] = 24'h6496C8;
    clear_capture();
    send_frame(0, 1'b0, 1'b0);
    check_frame("uniform", 1'b0);
    check("uniform_centre", 5, 5, {8'h0, got[5][5]}, 32'h6496C8);
    check("latency_5_7", 4, 6, 32'(out_edge[4][6] - acc_edge[5][7]), 32'd3);
    check("no_out_col0", 5, 0, {31'h0, dval_log[acc_edge[5][0] + 3]}, 32'h0);
    $display("phase uniform: %0d outputs", n_emit);

    // Single white pixel on black.
    for (int r = 0; r < TV; r++) for (int c = 0; c < TH; c++) img[r][c] = 24'h000000;
    img[5][7] = 24'hFFFFFF;
    clear_capture();
    send_frame(0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      check("white_tbl", white_tbl[i].row, white_tbl[i].col,
            {8'h0, got[white_tbl[i].row][white_tbl[i].col]}, {8'h0, white_tbl[i].exp});
    end
    nz = 0;
    for (int r = 0; r < TV; r++) for (int c = 0; c < TH; c++) if (got[r][c] != 24'h0) nz++;
    check("white_nonzero_count", -1, -1, 32'(nz), 32'd9);
    $display("phase white: %0d outputs", n_emit);

    // Border pass-through: ramp on row 0, distinct column-0 values, zeros elsewhere.
    for (int r = 0; r < TV; r++) for (int c = 0; c < TH; c++) img[r][c] = 24'h000000;
    for (int c = 0; c < TH; c++) img[0][c] = {8'(c * 10), 8'(c * 10 + 1), 8'(c * 10 + 2)};
    for (int r = 1; r < TV; r++) img[r][0] = {8'(r * 7), 8'(r), 8'(200 - r)};
    clear_capture();
    send_frame(0, 1'b0, 1'b0);
    for (int c = 0; c < TH - 1; c++)
      check("border_row0", 0, c, {8'h0, got[0][c]}, {8'h0, 8'(c * 10), 8'(c * 10 + 1), 8'(c * 10 + 2)});
    for (int r = 1; r < TV - 1; r++)
      check("border_col0", r, 0, {8'h0, got[r][0]}, {8'h0, 8'(r * 7), 8'(r), 8'(200 - r)});
    check_frame("border", 1'b0);
    $display("phase border: %0d outputs", n_emit);

    // Textured frame, continuous, with out-of-range pixels injected mid-frame.
    for (int r = 0; r < TV; r++) for (int c = 0; c < TH; c++) begin
      img[r][c]     = hash_pix(r, c);
      byp_img[r][c] = ((r + c) % 2) == 1;
    end
    clear_capture();
    send_frame(0, 1'b0, 1'b1);
    check_frame("textured", 1'b0);
    for (int r = 0; r < TV; r++) for (int c = 0; c < TH; c++) cont_got[r][c] = got[r][c];
    $display("phase textured: %0d outputs", n_emit);

    // Same frame, one pixel in three cycles, bypass toggling per pixel.
    clear_capture();
    send_frame(2, 1'b1, 1'b0);
    check_frame("gapped", 1'b1);
    for (int r = 0; r < TV - 1; r++) for (int c = 0; c < TH - 1; c++) begin
      if (!byp_img[r + 1][c + 1])
        check("gapped_vs_cont", r, c, {8'h0, got[r][c]}, {8'h0, cont_got[r][c]});
      else
        check("gapped_bypass", r, c, {8'h0, got[r][c]}, {8'h0, hash_pix(r, c)});
    end
    check("gapped_latency", 4, 6, 32'(out_edge[4][6] - acc_edge[5][7]), 32'd3);
    $display("phase gapped: %0d outputs", n_emit);

    // Asynchronous reset mid-line on row 10 with pixels in flight.
    clear_capture();
    for (int k = 0; k < 10 * TH + 6; k++) drive_pix(k / TH, k % TH, img[k / TH][k % TH], 1'b0);
    @(posedge clk);
    #2;
    check("pre_rst_dval", -1, -1, {31'h0, bus.oDVAL}, 32'h1);
    bus.iDVAL = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_dval", -1, -1, {31'h0, bus.oDVAL}, 32'h0);
    check("midrst_rgb", -1, -1, {8'h0, bus.oR, bus.oG, bus.oB}, 32'h0);
    check("midrst_coord", -1, -1, {6'h0, bus.oROW, bus.oCOL}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    emit_before = n_emit;
    idle(5);
    check("midrst_flushed", -1, -1, 32'(n_emit - emit_before), 32'd0);
    drive_pix(10, 6, img[10][6], 1'b0);
    a = last_acc;
    idle(6);
    check("post_rst_early", 9, 5, {31'h0, dval_log[a + 2]}, 32'h0);
    check("post_rst_dval", 9, 5, {31'h0, dval_log[a + 3]}, 32'h1);
    check("post_rst_coord", 9, 5, 32'(seen[9][5]), 32'd1);
    check("post_rst_latency", 9, 5, 32'(out_edge[9][5] - a), 32'd3);

    // Out-of-range column with iDVAL high.
    emit_before = n_emit;
    drive_pix(10, 700, 24'hFFFFFF, 1'b0);
    a = last_acc;
    idle(6);
    check("col700_no_dval", 10, 700, {31'h0, dval_log[a + 3]}, 32'h0);
    check("col700_no_emit", 10, 700, 32'(n_emit - emit_before), 32'd0);
    $display("phase reset/out-of-range done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
